// File: rtl/pc_sequencer_if.sv
// Control/status bundle between a fetch controller (master) and pc_sequencer (slave).
interface pc_sequencer_if #(
    parameter int unsigned AWIDTH    = 6,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned LW = $clog2(RAS_DEPTH + 1);

    logic              stall;
    logic              halt_req;
    logic              resume;
    logic [AWIDTH-1:0] inc;
    logic              br_en;
    logic [AWIDTH-1:0] br_off;
    logic              jmp_en;
    logic [AWIDTH-1:0] jmp_addr;
    logic              call_en;
    logic              ret_en;
    logic [AWIDTH-1:0] addr;
    logic              addr_valid;
    logic              halted;
    logic              fault;
    logic [LW-1:0]     ras_level;

    modport master (
        output stall, halt_req, resume, inc, br_en, br_off, jmp_en, jmp_addr, call_en, ret_en,
        input  addr, addr_valid, halted, fault, ras_level
    );

    modport slave (
        input  stall, halt_req, resume, inc, br_en, br_off, jmp_en, jmp_addr, call_en, ret_en,
        output addr, addr_valid, halted, fault, ras_level
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with priority next-address mux, return-address stack and halt FSM.
// Optional range check against MEM_DEPTH is enabled by defining BOUNDS_CHECK_EN.
module pc_sequencer #(
    parameter int unsigned       AWIDTH    = 6,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [AWIDTH-1:0] RST_ADDR  = '0,
    parameter int unsigned       MEM_DEPTH = 64
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam int unsigned LW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              fault_q, fault_d;
    logic [LW-1:0]     level_q, level_d;
    logic [AWIDTH-1:0] ras_q [RAS_DEPTH];
    logic [AWIDTH-1:0] ras_d [RAS_DEPTH];

    logic [AWIDTH-1:0] seq_addr;
    logic [AWIDTH-1:0] nxt_addr;
    logic [AWIDTH-1:0] top;
    logic              push, pop, err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StBoot;
            addr_q  <= RST_ADDR;
            fault_q <= 1'b0;
            level_q <= '0;
            ras_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fault_q <= fault_d;
            level_q <= level_d;
            ras_q   <= ras_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        fault_d  = fault_q;
        level_d  = level_q;
        ras_d    = ras_q;
        seq_addr = addr_q + bus.inc;
        nxt_addr = seq_addr;
        push     = 1'b0;
        pop      = 1'b0;
        err      = 1'b0;

        top = '0;
        for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
            if (level_q == LW'(i + 1)) top = ras_q[i];
        end

        // Priority: ret > call > jmp > branch > increment; br_off wraps as two's complement.
        if (bus.ret_en) begin
            nxt_addr = top;
            pop      = 1'b1;
            err      = (level_q == '0);
        end else if (bus.call_en) begin
            nxt_addr = bus.jmp_addr;
            push     = 1'b1;
            err      = (level_q == LW'(RAS_DEPTH));
        end else if (bus.jmp_en) begin
            nxt_addr = bus.jmp_addr;
        end else if (bus.br_en) begin
            nxt_addr = addr_q + bus.br_off;
        end

`ifdef BOUNDS_CHECK_EN
        if (32'(nxt_addr) >= MEM_DEPTH) err = 1'b1;
`endif

        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (!bus.stall) begin
                    if (err) begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                    end else begin
                        addr_d = nxt_addr;
                        if (push) begin
                            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                                if (level_q == LW'(i)) ras_d[i] = seq_addr;
                            end
                            level_d = level_q + 1'b1;
                        end
                        if (pop) level_d = level_q - 1'b1;
                    end
                end
                if (bus.halt_req) state_d = StHalt;
            end
            StHalt: begin
                if (bus.resume && !fault_q) state_d = StRun;
            end
            default: state_d = StBoot;
        endcase
    end

    assign bus.addr       = addr_q;
    assign bus.addr_valid = (state_q == StRun);
    assign bus.halted     = (state_q == StHalt);
    assign bus.fault      = fault_q;
    assign bus.ras_level  = level_q;
endmodule
